writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Write-direction partner of the instruction fetcher: performs every CPU-initiated memory write.
- Covers plain stores (STA/STX/STY), read-modify-write double writes (ASL/LSR/ROL/ROR/INC/DEC on memory), and stack pushes of 1, 2 or 3 bytes (PHA/PHP, JSR, BRK/IRQ).
- Sits between the execute stage and the memory bus arbiter.
- Owns the stack-pointer decrement sequence for pushes.

Parameters:
- REG_WIDTH, 8, data/register width.
- ADDR_WIDTH, 16, address bus width.
- STACK_BASE, 16'h0100, page base for stack addresses.

Ports:
- phi1  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  write request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_kind  in  3  request type: 0 STORE, 1 RMW, 2 PUSH1, 3 PUSH2, 4 PUSH3; 5-7 illegal.
- req_addr  in  ADDR_WIDTH  target address for STORE/RMW.
- req_data  in  16  STORE/RMW/PUSH1 use [7:0]; PUSH2/PUSH3 carry PC.
- req_orig  in  REG_WIDTH  original operand for the RMW dummy write.
- req_p  in  REG_WIDTH  status byte for PUSH3.
- sp_in  in  REG_WIDTH  current stack pointer, sampled at accept.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data_out  out  REG_WIDTH  write data.
- mem_we  out  1  write strobe; exactly one byte per asserted cycle.
- sp_out  out  REG_WIDTH  updated stack pointer.
- sp_we  out  1  sp_out valid this cycle.
- busy  out  1  state not IDLE.
- done  out  1  one-cycle pulse coinciding with the final write.
- err  out  1  one-cycle pulse for an illegal kind.

Behaviour:
- Reset is asynchronous. The following go to 0 immediately: all outputs except req_ready, state=IDLE, byte counter, latched request. req_ready=1 while in reset.
- Accept occurs when req_valid & req_ready at a posedge (cycle N). All request fields and sp_in are latched. req_valid while busy is ignored and not queued.
- All outputs are registered. The first mem_we is in cycle N+1. A kind writing k bytes has mem_we high for cycles N+1..N+k, with done high in cycle N+k. The unit returns to IDLE in cycle N+k+1 and can accept again at that posedge.
- States:
  - IDLE -> STORE | RMW_DUMMY | PUSH | ERR according to the latched kind.
  - STORE: write req_data[7:0] to req_addr, assert done -> IDLE.
  - RMW_DUMMY: write req_orig to req_addr -> RMW_FINAL.
  - RMW_FINAL: write req_data[7:0] to req_addr, assert done -> IDLE. The address must be identical in both cycles.
  - PUSH: counter loads k (1/2/3) and decrements each write. On the last write assert done -> IDLE.
  - ERR: no mem_we, err=1 for one cycle -> IDLE; done stays 0.
- Push data order, high byte first:
  - PUSH1: req_data[7:0].
  - PUSH2: PC[15:8], PC[7:0].
  - PUSH3: PC[15:8], PC[7:0], req_p.
- Push address is STACK_BASE | sp, where sp starts at the latched sp_in.
- After each push write, sp = sp - 1 (8-bit, 0x00 wraps to 0xFF). sp_out carries the post-decrement value and sp_we is high in every push write cycle. The final sp_out is sp_in - k mod 256.
- The B-flag/bit-5 content of req_p is the caller's responsibility and is written unmodified.
- mem_addr and mem_data_out hold their last driven values while mem_we=0. sp_out holds its value while sp_we=0.
- Reset mid-operation aborts: remaining writes are dropped, no done is issued, and sp_out returns to 0. The caller must re-issue the request.
- busy = (state != IDLE). req_ready = !busy.

Decomposition:
- Shared defines header, alongside REG_WIDTH/ADDR_WIDTH: WB_KIND_STORE/RMW/PUSH1/PUSH2/PUSH3 encodings, STACK_BASE default, WB state encodings (IDLE, STORE, RMW_DUMMY, RMW_FINAL, PUSH, ERR).
- No sub-module: a single FSM plus a 2-bit counter and a stack-address mux.

Test Plan:
- STORE, addr 0x1234, data 0xAB: one cycle with mem_we=1, mem_addr=0x1234, data=0xAB, done=1 in the same cycle, sp_we=0; req_ready=1 on the next cycle.
- RMW, addr 0x0042, orig 0x80, data 0x01: cycle N+1 writes 0x80 to 0x0042, cycle N+2 writes 0x01 to 0x0042 with done=1; exactly 2 mem_we cycles.
- PUSH3, sp_in 0xFD, PC 0xC123, P 0x34: writes 0x01FD=0xC1, 0x01FC=0x23, 0x01FB=0x34; sp_out 0xFC, 0xFB, 0xFA with sp_we each cycle; done on the third write.
- PUSH2, sp_in 0x00, PC 0x8001: writes 0x0100=0x80, then 0x01FF=0x01; final sp_out 0xFE (wrap).
- Reset asserted asynchronously between the 1st and 2nd write of a PUSH3: mem_we and sp_out drop to 0 immediately without waiting for a clock, no further writes, no done; req_ready=1 after release.
- req_kind=7 accepted: no mem_we, err=1 for exactly one cycle, done=0. A second req_valid held during that busy cycle is not accepted until IDLE.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared widths, request-kind encodings, FSM states and push helpers for the
// CPU write-back unit.
package writeback_unit_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;
  localparam int PC_WIDTH   = 16;

  localparam logic [ADDR_WIDTH-1:0] STACK_BASE_DEFAULT = 16'h0100;

  localparam logic [2:0] WB_KIND_STORE = 3'd0;
  localparam logic [2:0] WB_KIND_RMW   = 3'd1;
  localparam logic [2:0] WB_KIND_PUSH1 = 3'd2;
  localparam logic [2:0] WB_KIND_PUSH2 = 3'd3;
  localparam logic [2:0] WB_KIND_PUSH3 = 3'd4;

  typedef enum logic [2:0] {
    WB_IDLE      = 3'd0,
    WB_STORE     = 3'd1,
    WB_RMW_DUMMY = 3'd2,
    WB_RMW_FINAL = 3'd3,
    WB_PUSH      = 3'd4,
    WB_ERR       = 3'd5
  } wb_state_e;

  function automatic logic [1:0] push_len(input logic [2:0] kind);
    case (kind)
      WB_KIND_PUSH1: push_len = 2'd1;
      WB_KIND_PUSH2: push_len = 2'd2;
      default:       push_len = 2'd3;
    endcase
  endfunction

  // cnt is the number of writes still to go, including this one; high byte first.
  function automatic logic [REG_WIDTH-1:0] push_byte(input logic [2:0]          kind,
                                                     input logic [1:0]          cnt,
                                                     input logic [PC_WIDTH-1:0] pc,
                                                     input logic [REG_WIDTH-1:0] p);
    case (cnt)
      2'd3:    push_byte = pc[15:8];
      2'd2:    push_byte = (kind == WB_KIND_PUSH3) ? pc[7:0] : pc[15:8];
      default: push_byte = (kind == WB_KIND_PUSH3) ? p : pc[7:0];
    endcase
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Request and memory-write bus between the execute stage, the write-back unit
// and the memory arbiter.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_kind;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [PC_WIDTH-1:0]   req_data;
  logic [REG_WIDTH-1:0]  req_orig;
  logic [REG_WIDTH-1:0]  req_p;
  logic [REG_WIDTH-1:0]  sp_in;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_data_out;
  logic                  mem_we;
  logic [REG_WIDTH-1:0]  sp_out;
  logic                  sp_we;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  req_valid, req_kind, req_addr, req_data, req_orig, req_p, sp_in,
    output req_ready, mem_addr, mem_data_out, mem_we, sp_out, sp_we, busy, done, err
  );

  modport master (
    output req_valid, req_kind, req_addr, req_data, req_orig, req_p, sp_in,
    input  req_ready, mem_addr, mem_data_out, mem_we, sp_out, sp_we, busy, done, err
  );

endinterface

// File: rtl/writeback_unit.sv
// Performs every CPU-initiated memory write: stores, RMW double writes and
// 1/2/3-byte stack pushes with stack-pointer decrement.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = STACK_BASE_DEFAULT
) (
  input  logic              phi1,
  input  logic              reset_n,
  writeback_unit_if.slave   bus
);

  wb_state_e             r_state, w_state_next;
  logic [1:0]            r_cnt, w_cnt_next;

  logic [2:0]            r_kind;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0]   r_data;
  logic [REG_WIDTH-1:0]  r_orig, r_p;

  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [REG_WIDTH-1:0]  r_mem_data, w_mem_data;
  logic [REG_WIDTH-1:0]  r_sp_out, w_sp_out;
  logic                  r_mem_we, w_mem_we;
  logic                  r_sp_we, w_sp_we;
  logic                  r_done, w_done;
  logic                  r_err, w_err;

  logic                  w_idle, w_accept;
  logic [2:0]            w_kind;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [PC_WIDTH-1:0]   w_data;
  logic [REG_WIDTH-1:0]  w_orig, w_p, w_sp_cur;

  // Outputs are registered one edge ahead, so on the accept edge the request
  // is taken straight from the bus rather than from the latch.
  assign w_idle   = (r_state == WB_IDLE);
  assign w_accept = w_idle && bus.req_valid;
  assign w_kind   = w_idle ? bus.req_kind : r_kind;
  assign w_addr   = w_idle ? bus.req_addr : r_addr;
  assign w_data   = w_idle ? bus.req_data : r_data;
  assign w_orig   = w_idle ? bus.req_orig : r_orig;
  assign w_p      = w_idle ? bus.req_p    : r_p;
  assign w_sp_cur = w_idle ? bus.sp_in    : r_sp_out;

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WB_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      WB_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_kind)
            WB_KIND_STORE: w_state_next = WB_STORE;
            WB_KIND_RMW:   w_state_next = WB_RMW_DUMMY;
            WB_KIND_PUSH1, WB_KIND_PUSH2, WB_KIND_PUSH3: begin
              w_state_next = WB_PUSH;
              w_cnt_next   = push_len(bus.req_kind);
            end
            default:       w_state_next = WB_ERR;
          endcase
        end
      end
      WB_RMW_DUMMY: w_state_next = WB_RMW_FINAL;
      WB_PUSH: begin
        w_cnt_next = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_next = WB_IDLE;
      end
      default: w_state_next = WB_IDLE;
    endcase
  end

  always_comb begin
    w_mem_addr = r_mem_addr;
    w_mem_data = r_mem_data;
    w_sp_out   = r_sp_out;
    w_mem_we   = 1'b0;
    w_sp_we    = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (w_state_next)
      WB_STORE, WB_RMW_FINAL: begin
        w_mem_we   = 1'b1;
        w_mem_addr = w_addr;
        w_mem_data = w_data[7:0];
        w_done     = 1'b1;
      end
      WB_RMW_DUMMY: begin
        w_mem_we   = 1'b1;
        w_mem_addr = w_addr;
        w_mem_data = w_orig;
      end
      WB_PUSH: begin
        w_mem_we   = 1'b1;
        w_sp_we    = 1'b1;
        w_mem_addr = STACK_BASE | ADDR_WIDTH'(w_sp_cur);
        w_mem_data = push_byte(w_kind, w_cnt_next, w_data, w_p);
        w_sp_out   = w_sp_cur - REG_WIDTH'(1);
        w_done     = (w_cnt_next == 2'd1);
      end
      WB_ERR:  w_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_kind     <= 3'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_orig     <= '0;
      r_p        <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_sp_out   <= '0;
      r_mem_we   <= 1'b0;
      r_sp_we    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_kind <= bus.req_kind;
        r_addr <= bus.req_addr;
        r_data <= bus.req_data;
        r_orig <= bus.req_orig;
        r_p    <= bus.req_p;
      end
      r_mem_addr <= w_mem_addr;
      r_mem_data <= w_mem_data;
      r_sp_out   <= w_sp_out;
      r_mem_we   <= w_mem_we;
      r_sp_we    <= w_sp_we;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign bus.req_ready    = w_idle;
  assign bus.busy         = !w_idle;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_data_out = r_mem_data;
  assign bus.mem_we       = r_mem_we;
  assign bus.sp_out       = r_sp_out;
  assign bus.sp_we        = r_sp_we;
  assign bus.done         = r_done;
  assign bus.err          = r_err;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed, table-driven bench for writeback_unit plus hand-written sequences
// for asynchronous reset mid-push and the illegal-kind busy cycle.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  typedef struct {
    logic [2:0]        kind;
    logic [15:0]       addr;
    logic [15:0]       data;
    logic [7:0]        orig;
    logic [7:0]        p;
    logic [7:0]        sp;
    int                nw;
    bit                isPush;
    logic [2:0][15:0]  ea;
    logic [2:0][7:0]   ed;
    logic [2:0][7:0]   es;
  } vec_t;

  logic phi1 = 1'b0;
  logic reset_n = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs[8];

  logic [15:0] addrHold = 16'h0000;
  logic [7:0]  dataHold = 8'h00;
  logic [7:0]  spHold   = 8'h00;

  writeback_unit_if bus();

  writeback_unit #(.STACK_BASE(16'h0100)) dut (
    .phi1    (phi1),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 phi1 = ~phi1;

  function automatic vec_t mkVec(input logic [2:0] kind, input logic [15:0] addr,
                                 input logic [15:0] data, input logic [7:0] orig,
                                 input logic [7:0] p, input logic [7:0] sp,
                                 input int nw, input bit isPush,
                                 input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                                 input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    vec_t v;
    v.kind = kind; v.addr = addr; v.data = data; v.orig = orig; v.p = p; v.sp = sp;
    v.nw = nw; v.isPush = isPush;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.es[0] = s0; v.es[1] = s1; v.es[2] = s2;
    return v;
  endfunction

  task automatic step();
    @(posedge phi1);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one request for a single accept edge, then scrambles the bus so the
  // unit must be working from its own latched copy.
  task automatic applyStimulus(input logic [2:0] kind, input logic [15:0] addr,
                               input logic [15:0] data, input logic [7:0] orig,
                               input logic [7:0] p, input logic [7:0] sp);
    bus.req_valid = 1'b1;
    bus.req_kind  = kind;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_orig  = orig;
    bus.req_p     = p;
    bus.sp_in     = sp;
    step();
    bus.req_valid = 1'b0;
    bus.req_kind  = WB_KIND_STORE;
    bus.req_addr  = 16'hDEAD;
    bus.req_data  = 16'hBEEF;
    bus.req_orig  = 8'h11;
    bus.req_p     = 8'h22;
    bus.sp_in     = 8'h77;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " mem_we"},    32'(bus.mem_we),       32'd0);
    checkOutput({tag, " done"},      32'(bus.done),         32'd0);
    checkOutput({tag, " err"},       32'(bus.err),          32'd0);
    checkOutput({tag, " sp_we"},     32'(bus.sp_we),        32'd0);
    checkOutput({tag, " req_ready"}, 32'(bus.req_ready),    32'd1);
    checkOutput({tag, " busy"},      32'(bus.busy),         32'd0);
    checkOutput({tag, " addr hold"}, 32'(bus.mem_addr),     32'(addrHold));
    checkOutput({tag, " data hold"}, 32'(bus.mem_data_out), 32'(dataHold));
    checkOutput({tag, " sp hold"},   32'(bus.sp_out),       32'(spHold));
  endtask

  initial begin
    vecs[0] = mkVec(WB_KIND_STORE, 16'h1234, 16'h00AB, 8'h00, 8'h00, 8'h55, 1, 0,
                    16'h1234, 16'h0, 16'h0, 8'hAB, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    vecs[1] = mkVec(WB_KIND_RMW, 16'h0042, 16'h0001, 8'h80, 8'h00, 8'h00, 2, 0,
                    16'h0042, 16'h0042, 16'h0, 8'h80, 8'h01, 8'h0, 8'h0, 8'h0, 8'h0);
    vecs[2] = mkVec(WB_KIND_PUSH3, 16'h0000, 16'hC123, 8'h00, 8'h34, 8'hFD, 3, 1,
                    16'h01FD, 16'h01FC, 16'h01FB, 8'hC1, 8'h23, 8'h34, 8'hFC, 8'hFB, 8'hFA);
    vecs[3] = mkVec(WB_KIND_PUSH2, 16'h0000, 16'h8001, 8'h00, 8'h99, 8'h00, 2, 1,
                    16'h0100, 16'h01FF, 16'h0, 8'h80, 8'h01, 8'h0, 8'hFF, 8'hFE, 8'h0);
    vecs[4] = mkVec(WB_KIND_PUSH1, 16'h0000, 16'h775A, 8'h00, 8'h99, 8'h01, 1, 1,
                    16'h0101, 16'h0, 16'h0, 8'h5A, 8'h0, 8'h0, 8'h00, 8'h0, 8'h0);
    vecs[5] = mkVec(3'd7, 16'h4444, 16'h0055, 8'h66, 8'h00, 8'h10, 0, 0,
                    16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    vecs[6] = mkVec(3'd5, 16'h5555, 16'h0066, 8'h77, 8'h00, 8'h20, 0, 0,
                    16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    vecs[7] = mkVec(WB_KIND_STORE, 16'hFFFF, 16'h1200, 8'h33, 8'h00, 8'h40, 1, 0,
                    16'hFFFF, 16'h0, 16'h0, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);

    bus.req_valid = 1'b0;
    bus.req_kind  = 3'd0;
    bus.req_addr  = 16'h0;
    bus.req_data  = 16'h0;
    bus.req_orig  = 8'h0;
    bus.req_p     = 8'h0;
    bus.sp_in     = 8'h0;

    #1;
    checkIdle("reset");
    #11 reset_n = 1'b1;
    step();
    checkIdle("post-reset");

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      applyStimulus(vecs[i].kind, vecs[i].addr, vecs[i].data, vecs[i].orig, vecs[i].p, vecs[i].sp);
      if (vecs[i].nw == 0) begin
        checkOutput({tag, " err"},       32'(bus.err),       32'd1);
        checkOutput({tag, " mem_we"},    32'(bus.mem_we),    32'd0);
        checkOutput({tag, " done"},      32'(bus.done),      32'd0);
        checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
      end else begin
        for (int j = 0; j < vecs[i].nw; j++) begin
          string wt;
          wt = $sformatf("%s w%0d", tag, j);
          checkOutput({wt, " mem_we"}, 32'(bus.mem_we),       32'd1);
          checkOutput({wt, " addr"},   32'(bus.mem_addr),     32'(vecs[i].ea[j]));
          checkOutput({wt, " data"},   32'(bus.mem_data_out), 32'(vecs[i].ed[j]));
          checkOutput({wt, " done"},   32'(bus.done),         32'(j == vecs[i].nw - 1));
          checkOutput({wt, " err"},    32'(bus.err),          32'd0);
          checkOutput({wt, " sp_we"},  32'(bus.sp_we),        32'(vecs[i].isPush));
          if (vecs[i].isPush) spHold = vecs[i].es[j];
          checkOutput({wt, " sp_out"}, 32'(bus.sp_out),       32'(spHold));
          addrHold = vecs[i].ea[j];
          dataHold = vecs[i].ed[j];
          if (j < vecs[i].nw - 1) step();
        end
      end
      step();
      checkIdle({tag, " end"});
    end

    // Asynchronous reset between the first and second write of a PUSH3.
    applyStimulus(WB_KIND_PUSH3, 16'h0000, 16'hC123, 8'h00, 8'h34, 8'hFD);
    checkOutput("rst w0 mem_we", 32'(bus.mem_we), 32'd1);
    checkOutput("rst w0 sp_out", 32'(bus.sp_out), 32'h0FC);
    #2 reset_n = 1'b0;
    #1;
    addrHold = 16'h0000;
    dataHold = 8'h00;
    spHold   = 8'h00;
    checkIdle("rst async");
    step();
    checkIdle("rst held");
    #3 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checkIdle($sformatf("rst after%0d", k));
    end

    // Illegal kind with a second request held through the ERR cycle.
    bus.req_valid = 1'b1;
    bus.req_kind  = 3'd7;
    bus.req_addr  = 16'h1111;
    bus.req_data  = 16'h0099;
    bus.sp_in     = 8'h30;
    step();
    checkOutput("err pulse",     32'(bus.err),       32'd1);
    checkOutput("err busy",      32'(bus.busy),      32'd1);
    checkOutput("err req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("err mem_we",    32'(bus.mem_we),    32'd0);
    checkOutput("err done",      32'(bus.done),      32'd0);
    bus.req_kind = WB_KIND_STORE;
    bus.req_addr = 16'h2222;
    bus.req_data = 16'h0033;
    step();
    checkIdle("err held");
    step();
    bus.req_valid = 1'b0;
    checkOutput("held store mem_we", 32'(bus.mem_we),       32'd1);
    checkOutput("held store addr",   32'(bus.mem_addr),     32'h2222);
    checkOutput("held store data",   32'(bus.mem_data_out), 32'h33);
    checkOutput("held store done",   32'(bus.done),         32'd1);
    addrHold = 16'h2222;
    dataHold = 8'h33;
    step();
    checkIdle("held store end");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
